// File: rtl/seq_div_param.sv
// Restoring divider: signed/unsigned W-bit quotient and remainder, with divide-by-zero and overflow flags.
// Latency: W+1 edges from accepting start to the done pulse (1 edge for divide-by-zero).
// Backpressure: start is ignored while busy; done is a one-cycle pulse that needs no acknowledge.
module seq_div_param #(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic         ovf
);

    localparam int          CW  = $clog2(W + 1);
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state;
    logic [W-1:0]  a;          // partial remainder
    logic [W-1:0]  q;          // quotient bits shift in here; holds raw dividend on the dbz path
    logic [W-1:0]  dvs;        // divisor magnitude
    logic [CW-1:0] cnt;
    logic          sgn_dd;
    logic          sgn_dv;
    logic          dbz_path;
    logic          ovf_pend;

    logic          dd_neg;
    logic          dv_neg;
    logic [W-1:0]  dd_mag;
    logic [W-1:0]  dv_mag;
    logic [W:0]    a_sh;
    logic [W:0]    trial;

    // Operand magnitudes and one restoring step; trial is one bit wider so its MSB is the sign.
    always_comb begin
        dd_neg = SIGNED && dividend[W-1];
        dv_neg = SIGNED && divisor[W-1];
        dd_mag = dd_neg ? -dividend : dividend;
        dv_mag = dv_neg ? -divisor  : divisor;
        a_sh   = {a, q[W-1]};
        trial  = a_sh - {1'b0, dvs};
    end

    // Control FSM with registered results; MIN/-1 needs no special datapath since 2^(W-1) wraps to MIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            a        <= '0;
            q        <= '0;
            dvs      <= '0;
            cnt      <= '0;
            sgn_dd   <= 1'b0;
            sgn_dv   <= 1'b0;
            dbz_path <= 1'b0;
            ovf_pend <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        dbz      <= 1'b0;
                        ovf      <= 1'b0;
                        sgn_dd   <= dd_neg;
                        sgn_dv   <= dv_neg;
                        dvs      <= dv_mag;
                        a        <= '0;
                        cnt      <= '0;
                        ovf_pend <= SIGNED && (dividend == MIN) && (divisor == '1);
                        if (divisor == '0) begin
                            dbz_path <= 1'b1;
                            q        <= dividend;
                            state    <= FIX;
                        end else begin
                            dbz_path <= 1'b0;
                            q        <= dd_mag;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    a   <= trial[W] ? a_sh[W-1:0] : trial[W-1:0];
                    q   <= {q[W-2:0], ~trial[W]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dbz_path) begin
                        quot <= '1;
                        rem  <= q;
                        dbz  <= 1'b1;
                    end else begin
                        quot <= (sgn_dd ^ sgn_dv) ? -q : q;
                        rem  <= sgn_dd ? -a : a;
                        ovf  <= ovf_pend;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_param.sv
// Directed bench for seq_div_param: an 8-bit signed and a 16-bit unsigned instance.
// Table-driven vectors back-to-back, plus hand sequences for ignored start and mid-op reset.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_seq_div_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  dd8 = '0, dv8 = '0, quot8, rem8;
    logic        busy8, done8, dbz8, ovf8;

    logic        start16 = 1'b0;
    logic [15:0] dd16 = '0, dv16 = '0, quot16, rem16;
    logic        busy16, done16, dbz16, ovf16;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_div_param #(.W(8), .SIGNED(1'b1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dd8), .divisor(dv8),
        .quot(quot8), .rem(rem8), .busy(busy8), .done(done8), .dbz(dbz8), .ovf(ovf8)
    );

    seq_div_param #(.W(16), .SIGNED(1'b0)) u16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(dd16), .divisor(dv16),
        .quot(quot16), .rem(rem16), .busy(busy16), .done(done16), .dbz(dbz16), .ovf(ovf16)
    );

    typedef struct {
        logic [7:0] dd;
        logic [7:0] dv;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // done and busy must never overlap
    always @(negedge clk) begin
        if (rst) begin
            n_chk++;
            if ((busy8 && done8) || (busy16 && done16)) begin
                n_fail++;
                $display("FAIL busy_done_overlap: got busy8=%b done8=%b busy16=%b done16=%b, expected no overlap",
                         busy8, done8, busy16, done16);
            end
        end
    end

    // Caller is at a falling edge; returns at the falling edge after the accepting edge.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input string nm);
        dd8 = a; dv8 = b; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        chk({nm, "_busy"}, 32'(busy8), 32'd1);
    endtask

    task automatic wait8(input int lat_in, output int lat);
        lat = lat_in;
        while (!done8 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic result8(input string nm, input int lat, input vec_t v);
        chk({nm, "_lat"},  32'(lat),  32'(v.lat));
        chk({nm, "_done"}, 32'(done8), 32'd1);
        chk({nm, "_quot"}, 32'(quot8), 32'(v.q));
        chk({nm, "_rem"},  32'(rem8),  32'(v.r));
        chk({nm, "_dbz"},  32'(dbz8),  32'(v.dbz));
        chk({nm, "_ovf"},  32'(ovf8),  32'(v.ovf));
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edbz, input int elat, input string nm);
        int lat;
        dd16 = a; dv16 = b; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, "_lat"},  32'(lat),    32'(elat));
        chk({nm, "_quot"}, 32'(quot16), 32'(eq));
        chk({nm, "_rem"},  32'(rem16),  32'(er));
        chk({nm, "_dbz"},  32'(dbz16),  32'(edbz));
        chk({nm, "_ovf"},  32'(ovf16),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        vec_t v;

        //            dd     dv     q      r      dbz   ovf   lat
        tbl[0] = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 9};
        tbl[1] = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 9};   // -100 / 7
        tbl[2] = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 9};   // 100 / -7
        tbl[3] = '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 9};   // -100 / -7
        tbl[4] = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 9};   // MIN / -1
        tbl[5] = '{8'd5,   8'd0,   8'hFF, 8'h05, 1'b1, 1'b0, 1};   // divide by zero
        tbl[6] = '{8'd0,   8'd9,   8'h00, 8'h00, 1'b0, 1'b0, 9};
        tbl[7] = '{8'd9,   8'd2,   8'h04, 8'h01, 1'b0, 1'b0, 9};
        tbl[8] = '{8'hFB,  8'd0,   8'hFF, 8'hFB, 1'b1, 1'b0, 1};   // -5 / 0 keeps raw dividend
        tbl[9] = '{8'h80,  8'd1,   8'h80, 8'h00, 1'b0, 1'b0, 9};   // MIN / 1 is not overflow

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_quot8", 32'(quot8), 32'd0);
        chk("rst_rem8",  32'(rem8),  32'd0);
        chk("rst_flags8", 32'({busy8, done8, dbz8, ovf8}), 32'd0);
        chk("rst_out16", 32'({quot16, rem16}), 32'd0);
        chk("rst_flags16", 32'({busy16, done16, dbz16, ovf16}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table vectors, each launched in the done cycle of the previous one
        for (int i = 0; i < 10; i++) begin
            v = tbl[i];
            launch8(v.dd, v.dv, $sformatf("vec%0d", i));
            wait8(0, lat);
            result8($sformatf("vec%0d", i), lat, v);
        end
        @(negedge clk);
        chk("done_clears", 32'(done8), 32'd0);

        // start pulsed while busy must not disturb the running division
        launch8(8'd100, 8'd7, "ign");
        lat = 0;
        repeat (2) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        dd8 = 8'd50; dv8 = 8'd3; start8 = 1'b1;
        @(posedge clk); lat++; @(negedge clk);
        start8 = 1'b0;
        dd8 = 8'd0; dv8 = 8'd0;
        wait8(lat, lat);
        result8("ign", lat, '{8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 9});
        @(negedge clk);
        chk("ign_no_second_done", 32'({busy8, done8}), 32'd0);

        // Reset in the middle of a division clears everything at once
        launch8(8'd77, 8'd5, "mid");
        repeat (4) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_quot", 32'(quot8), 32'd0);
        chk("mid_rst_rem",  32'(rem8),  32'd0);
        chk("mid_rst_flags", 32'({busy8, done8, dbz8, ovf8}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        lat = 0;
        repeat (12) begin
            @(posedge clk); @(negedge clk);
            if (done8 || busy8) lat++;
        end
        chk("mid_rst_no_done", 32'(lat), 32'd0);
        launch8(8'd20, 8'd6, "post");
        wait8(0, lat);
        result8("post", lat, '{8'd20, 8'd6, 8'h03, 8'h02, 1'b0, 1'b0, 9});
        @(negedge clk);

        // Unsigned 16-bit instance
        run16(16'd60000, 16'd7,      16'd8571, 16'd3,    1'b0, 17, "u16_a");
        run16(16'hFFFF,  16'hFFFF,   16'd1,    16'd0,    1'b0, 17, "u16_b");
        run16(16'd1234,  16'd0,      16'hFFFF, 16'd1234, 1'b1, 1,  "u16_dbz");
        run16(16'h8000,  16'hFFFF,   16'd0,    16'h8000, 1'b0, 17, "u16_big");
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
